// File: rtl/mul12_seq_ctrl_pkg.sv
// Shared types and constants for the 12x12 sequential multiplier controller.
// Covers state/step encodings, widths, and per-step operand and shift selection.
package mul12_seq_ctrl_pkg;

   localparam int HALF_W = 6;
   localparam int OP_W   = 2 * HALF_W;
   localparam int PROD_W = 2 * OP_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Step names give the half of x and the half of y fed to the core.
   typedef enum logic [1:0] {
      STEP_LL = 2'd0,
      STEP_LH = 2'd1,
      STEP_HL = 2'd2,
      STEP_HH = 2'd3
   } step_e;

   typedef struct packed {
      logic [HALF_W-1:0] a;
      logic [HALF_W-1:0] b;
   } core_ops_t;

   function automatic logic [4:0] step_shift(step_e s);
      case (s)
         STEP_LL: return 5'd0;
         STEP_LH: return 5'd6;
         STEP_HL: return 5'd6;
         default: return 5'd12;
      endcase
   endfunction

   function automatic core_ops_t step_ops(step_e s, logic [OP_W-1:0] x, logic [OP_W-1:0] y);
      core_ops_t ops;
      ops.a = (s inside {STEP_LL, STEP_LH}) ? x[HALF_W-1:0] : x[OP_W-1:HALF_W];
      ops.b = (s inside {STEP_LL, STEP_HL}) ? y[HALF_W-1:0] : y[OP_W-1:HALF_W];
      return ops;
   endfunction

endpackage

// File: rtl/mul12_seq_ctrl_if.sv
// Operand, result and shared-core signals of the sequential multiplier controller.
// master is the controller side; slave is the surrounding source, sink and core.
interface mul12_seq_ctrl_if;
   import mul12_seq_ctrl_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   x;
   logic [OP_W-1:0]   y;
   logic [HALF_W-1:0] mul_a;
   logic [HALF_W-1:0] mul_b;
   logic [OP_W-1:0]   mul_p;
   logic              mul_en;
   logic              out_valid;
   logic              out_ready;
   logic [PROD_W-1:0] prod;

   modport master (
      input  in_valid, x, y, mul_p, out_ready,
      output in_ready, mul_a, mul_b, mul_en, out_valid, prod
   );

   modport slave (
      output in_valid, x, y, mul_p, out_ready,
      input  in_ready, mul_a, mul_b, mul_en, out_valid, prod
   );

endinterface

// File: rtl/mul12_seq_ctrl.sv
// Sequences a 12x12 unsigned multiply over an external combinational 6x6 core,
// accumulating up to four shifted partial products into a 24-bit result.
module mul12_seq_ctrl
   import mul12_seq_ctrl_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b1,
   parameter int HALF_W     = 6
) (
   input  logic clk,
   input  logic rst_n,
   mul12_seq_ctrl_if.master bus
);

   state_e            state_q;
   step_e             step_q;
   logic [OP_W-1:0]   x_q;
   logic [OP_W-1:0]   y_q;
   logic [PROD_W-1:0] acc_q;
   logic [PROD_W-1:0] prod_q;
   logic [HALF_W-1:0] mul_a_q;
   logic [HALF_W-1:0] mul_b_q;
   logic              mul_en_q;
   logic              out_valid_q;
   logic              in_ready_q;

   logic [PROD_W-1:0] acc_d;
   step_e             step_d;
   core_ops_t         ops_first;
   core_ops_t         ops_next;
   logic              last_step;

   // NOTE: every signal written here gets a default at the top so no path leaves it unassigned (no latch).
   always_comb begin
      acc_d     = acc_q + (PROD_W'(bus.mul_p) << step_shift(step_q));
      step_d    = step_e'(step_q + 2'd1);
      ops_first = step_ops(STEP_LL, bus.x, bus.y);
      ops_next  = step_ops(step_d, x_q, y_q);
      last_step = (step_q == STEP_HH);
      // With a zero upper half of x the two remaining partial products are zero.
      if (EARLY_EXIT && step_q == STEP_LH && x_q[2*HALF_W-1:HALF_W] == '0) begin
         last_step = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         step_q      <= STEP_LL;
         x_q         <= '0;
         y_q         <= '0;
         acc_q       <= '0;
         prod_q      <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  x_q        <= bus.x;
                  y_q        <= bus.y;
                  acc_q      <= '0;
                  step_q     <= STEP_LL;
                  mul_a_q    <= ops_first.a;
                  mul_b_q    <= ops_first.b;
                  mul_en_q   <= 1'b1;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_MUL;
               end
            end

            ST_MUL: begin
               acc_q <= acc_d;
               if (last_step) begin
                  prod_q      <= acc_d;
                  out_valid_q <= 1'b1;
                  mul_a_q     <= '0;
                  mul_b_q     <= '0;
                  mul_en_q    <= 1'b0;
                  state_q     <= ST_DONE;
               end else begin
                  step_q  <= step_d;
                  mul_a_q <= ops_next.a;
                  mul_b_q <= ops_next.b;
               end
            end

            ST_DONE: begin
               // New operands are only taken in the following IDLE cycle.
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.mul_en    = mul_en_q;
   assign bus.out_valid = out_valid_q;
   assign bus.prod      = prod_q;

endmodule

// File: tb/tb_mul12_seq_ctrl.sv
// Directed bench for mul12_seq_ctrl with an ideal 6x6 core and an in-order result scoreboard.
module tb_mul12_seq_ctrl;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   n_results = 0;

   mul12_seq_ctrl_if bus ();

   mul12_seq_ctrl #(.EARLY_EXIT(1'b1), .HALF_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Ideal combinational 6x6 core.
   always_comb bus.mul_p = 12'(bus.mul_a) * 12'(bus.mul_b);

   typedef struct {
      logic [23:0] prod;
      int          steps;
      logic [11:0] x;
      logic [11:0] y;
      int          acc_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   en_cnt  = 0;
   logic prev_ov = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [5:0]  ea;
      logic [5:0]  eb;
      if (!rst_n) begin
         exp_q.delete();
         en_cnt  = 0;
         prev_ov = 1'b0;
      end else begin
         check("in_ready_only_idle", 32'(bus.in_ready), 32'(!(bus.mul_en || bus.out_valid)));
         if (!bus.mul_en) check("core_quiet", {bus.mul_a, bus.mul_b}, 32'h0);
         if (bus.in_valid && bus.in_ready) begin
            e.x       = bus.x;
            e.y       = bus.y;
            e.prod    = 24'(bus.x) * 24'(bus.y);
            e.steps   = (bus.x[11:6] == 6'd0) ? 2 : 4;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            en_cnt = 0;
         end else if (bus.mul_en) begin
            check("mul_en_has_op", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
               ea = (en_cnt < 2) ? exp_q[0].x[5:0] : exp_q[0].x[11:6];
               eb = (en_cnt % 2 == 0) ? exp_q[0].y[5:0] : exp_q[0].y[11:6];
               check("core_operands", {bus.mul_a, bus.mul_b}, {20'h0, ea, eb});
            end
            en_cnt++;
         end
         if (bus.out_valid) begin
            check("out_valid_has_op", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
               check("prod", 32'(bus.prod), 32'(exp_q[0].prod));
               if (!prev_ov) begin
                  check("latency", 32'(cyc - exp_q[0].acc_cyc - 1), 32'(exp_q[0].steps));
                  check("mul_en_cycles", 32'(en_cnt), 32'(exp_q[0].steps));
               end
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  n_results++;
               end
            end
         end
         prev_ov = bus.out_valid;
      end
   end

   task automatic send(input logic [11:0] xv, input logic [11:0] yv);
      logic ok = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.x = xv;
      bus.y = yv;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("accept_in_time", 32'(ok), 32'h1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.x = 12'($urandom);
      bus.y = 12'($urandom);
   endtask

   task automatic run_op(input logic [11:0] xv, input logic [11:0] yv, input int stall);
      logic ok = 1'b0;
      send(xv, yv);
      bus.out_ready = (stall == 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("result_in_time", 32'(ok), 32'h1);
      if (stall > 0) begin
         repeat (stall - 1) begin
            @(negedge clk);
            check("in_ready_low_while_held", 32'(bus.in_ready), 32'h0);
         end
         @(posedge clk); #1;
         bus.out_ready = 1'b1;
         @(negedge clk);
         check("in_ready_low_at_ack", 32'(bus.in_ready), 32'h0);
      end
      @(negedge clk);
      check("in_ready_after_ack", 32'(bus.in_ready), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic drained;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.x         = '0;
      bus.y         = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_mul_en", 32'(bus.mul_en), 32'h0);
      check("rst_core_ops", {bus.mul_a, bus.mul_b}, 32'h0);
      check("rst_prod", 32'(bus.prod), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_op(12'hFFF, 12'hFFF, 0);
      check("full_prod_value", 32'(bus.prod), 32'hFFE001);
      run_op(12'h03F, 12'hFFF, 0);
      check("early_prod_value", 32'(bus.prod), 32'h03EFC1);
      run_op(12'h040, 12'h003, 0);
      check("xh_nonzero_prod", 32'(bus.prod), 32'h0000C0);
      run_op(12'h123, 12'h456, 3);
      check("stall_prod_value", 32'(bus.prod), 32'h04EDC2);

      // Abort an operation during its third step.
      send(12'h123, 12'h456);
      repeat (3) @(negedge clk);
      check("mid_op_busy", 32'(bus.mul_en), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'h0);
      check("abort_core_ops", {bus.mul_a, bus.mul_b}, 32'h0);
      check("abort_mul_en", 32'(bus.mul_en), 32'h0);
      check("abort_in_ready", 32'(bus.in_ready), 32'h1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_abort_in_ready", 32'(bus.in_ready), 32'h1);
      check("post_abort_out_valid", 32'(bus.out_valid), 32'h0);
      repeat (6) @(negedge clk);
      run_op(12'd2, 12'd3, 0);
      check("post_abort_prod", 32'(bus.prod), 32'd6);

      // in_valid held high across eight back-to-back operands.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic ok = 1'b0;
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.x = 12'($urandom_range(0, 4095));
         bus.y = 12'($urandom_range(0, 4095));
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
               ok = 1'b1;
               break;
            end
         end
         check("stream_accept", 32'(ok), 32'h1);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      drained = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      check("scoreboard_drained", 32'(drained), 32'h1);
      check("result_count", 32'(n_results), 32'd13);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
